// File: rtl/tc_ser_ctrl_if.sv
// Word-side handshake bundle for tc_ser_ctrl: input word channel, result channel
// and a debug view of the sequencer state.
interface tc_ser_ctrl_if #(
    parameter int W = 8
);
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_ready;
    logic         out_ovf;
    logic [1:0]   state_dbg;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf, state_dbg
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, state_dbg
    );
endinterface

// File: rtl/tc_ser_ctrl.sv
// Word-level sequencer feeding a bit-serial two's-complement core LSB-first.
// Optional overflow flag for the most-negative input is built when TC_OVF_EN is defined.
module tc_ser_ctrl #(
    parameter int W = 8
) (
    input  logic          t_clk,
    input  logic          r,
    tc_ser_ctrl_if.slave  bus,
    output logic          busy,
    output logic          core_i,
    output logic          core_r,
    input  logic          core_y
);
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   sreg_q, sreg_d;
    logic [W-1:0]   res_q, res_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; ready never depends combinationally on valid on either channel.
    always_ff @(posedge t_clk or negedge r) begin
        if (!r) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef TC_OVF_EN
    logic msb_q, msb_d;

    always_ff @(posedge t_clk or negedge r) begin
        if (!r) msb_q <= 1'b0;
        else    msb_q <= msb_d;
    end

    always_comb begin
        msb_d = msb_q;
        if (state_q == IDLE && bus.in_valid) msb_d = bus.in_data[W-1];
    end

    assign bus.out_ovf = (state_q == DONE) & msb_q & res_q[W-1];
`else
    assign bus.out_ovf = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sreg_d  = bus.in_data;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                res_d  = {core_y, res_q[W-1:1]};
                sreg_d = sreg_q >> 1;
                // Counter parks at zero on the final capture so it never wraps.
                if (cnt_q == CW'(W - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = (state_q == DONE) ? res_q : '0;
    assign bus.state_dbg = state_q;
    assign busy          = (state_q != IDLE);
    assign core_r        = (state_q != SHIFT);
    assign core_i        = (state_q == SHIFT) & sreg_q[0];
endmodule

// File: tb/tb_tc_ser_ctrl.sv
// Directed plus randomized bench for tc_ser_ctrl with a behavioural serial core
// and an arithmetic reference for the two's complement of each word.
module tb_tc_ser_ctrl;
    localparam int W = 8;

    logic t_clk = 1'b0;
    logic r     = 1'b0;
    logic busy, core_i, core_r, core_y;
    logic seen_one = 1'b0;

    int n_vec = 0;
    int n_mis = 0;
    logic [W-1:0] exp_q[$];

    tc_ser_ctrl_if #(.W(W)) bus ();

    tc_ser_ctrl #(.W(W)) dut (
        .t_clk  (t_clk),
        .r      (r),
        .bus    (bus.slave),
        .busy   (busy),
        .core_i (core_i),
        .core_r (core_r),
        .core_y (core_y)
    );

    // Clock and reset
    always #5 t_clk = ~t_clk;

    // Serial complementer: pass bits up to and including the first 1, invert after.
    always @(posedge t_clk) begin
        if (core_r)      seen_one <= 1'b0;
        else if (core_i) seen_one <= 1'b1;
    end
    assign core_y = core_i ^ seen_one;

    function automatic logic [W-1:0] ref_neg(input logic [W-1:0] x);
        int v;
        v = (256 - int'(x)) % 256;
        return v[W-1:0];
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x);
`ifdef TC_OVF_EN
        return (x == 8'h80);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge t_clk);
        #1;
    endtask

    // Drives one word, checks every SHIFT cycle and the DONE result; leaves DUT in DONE.
    task automatic run_word(input logic [W-1:0] x);
        logic [W-1:0] e;
        e = ref_neg(x);
        exp_q.push_back(e);
        bus.in_valid = 1'b1;
        bus.in_data  = x;
        check("in_ready_before_accept", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = W'($urandom_range(0, 255));
        for (int k = 0; k < W; k++) begin
            check("core_i_bit", core_i, (x >> k) & 1);
            check("core_r_low", core_r, 0);
            check("out_valid_early", bus.out_valid, 0);
            tick();
        end
        check("out_valid_at_latency", bus.out_valid, 1);
        check("core_r_done", core_r, 1);
        check("out_data", bus.out_data, exp_q.pop_front());
        check("out_ovf", bus.out_ovf, ref_ovf(x));
    endtask

    task automatic release_done();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("idle_after_release", bus.in_ready, 1);
        check("out_valid_cleared", bus.out_valid, 0);
        check("busy_cleared", busy, 0);
    endtask

    initial begin
        logic [W-1:0] held;
        logic [W-1:0] words[3];
        int idx, got, last_cyc, cyc;
        logic acc;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset values
        #2;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_core_r", core_r, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_ovf", bus.out_ovf, 0);
        check("rst_busy", busy, 0);
        check("rst_core_i", core_i, 0);
        tick();
        tick();
        r = 1'b1;
        tick();

        // Basic results, bit-level drive and corner values
        run_word(8'h01); release_done();
        run_word(8'h7F); release_done();
        run_word(8'h06); release_done();
        run_word(8'h00); release_done();
        run_word(8'h80); release_done();

        // Backpressure: DONE held, extra input ignored
        run_word(8'h33);
        held = bus.out_data;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = (c == 2);
            bus.in_data  = 8'hAA;
            tick();
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_out_data", bus.out_data, ref_neg(8'h33));
            check("bp_in_ready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        check("bp_stable", bus.out_data, held);
        release_done();
        run_word(8'h02); release_done();

        // Reset mid-SHIFT
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        tick();
        bus.in_valid = 1'b0;
        tick(); tick(); tick();
        #1 r = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_core_r", core_r, 1);
        tick();
        #2 r = 1'b1;
        tick();
        run_word(8'h05); release_done();

        // Randomized words against the arithmetic reference
        for (int n = 0; n < 20; n++) begin
            run_word(W'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 1) tick();
            release_done();
        end

        // Back-to-back streaming with both valid and ready held high
        words[0] = 8'h03; words[1] = 8'h10; words[2] = 8'hFF;
        exp_q.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(ref_neg(words[i]));
        idx = 0; got = 0; last_cyc = -1; cyc = 0;
        bus.in_data   = words[0];
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        while (got < 3 && cyc < 60) begin
            acc = bus.in_ready & bus.in_valid;
            tick();
            cyc++;
            if (acc) begin
                idx++;
                if (idx < 3) bus.in_data = words[idx];
                else bus.in_valid = 1'b0;
            end
            if (bus.out_valid) begin
                check("b2b_data", bus.out_data, exp_q.pop_front());
                if (last_cyc >= 0) check("b2b_period", cyc - last_cyc, 10);
                last_cyc = cyc;
                got++;
            end
        end
        check("b2b_result_count", got, 3);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule

// File: doc/tc_ser_ctrl.md
# tc_ser_ctrl

Word-level sequencer for the serial two's-complement core (`invert`). It accepts a W-bit word over a valid/ready handshake and shifts it LSB-first into the core. It clears the core before each word, collects the core's serial output back into a W-bit result, and presents that result on an output handshake. It sits between parallel producers and consumers and the bit-serial complementer.

## Interface

**Parameters**
- `W`, default 8: word width, minimum 2.

**Ports** (all port widths in bits)
- `t_clk` in 1: clock; everything is sampled on its rising edge.
- `r` in 1: asynchronous reset, active-low.
- `in_valid` in 1: input word is valid.
- `in_data` in W: word to be complemented.
- `in_ready` out 1: block can accept a word.
- `out_valid` out 1: result is valid.
- `out_data` out W: two's complement of the accepted word.
- `out_ready` in 1: consumer takes the result.
- `out_ovf` out 1: input was -2^(W-1) (see Configuration).
- `busy` out 1: a word is in flight.
- `core_i` out 1: serial bit driven to the core's `i`.
- `core_r` out 1: drives the core's `r`, active-high clear.
- `core_y` in 1: core output `y`. It is a combinational Mealy output of `core_i` and the core state.

## Operation

**States:** IDLE, SHIFT, DONE. Encoding is free.

**IDLE**
- `in_ready`=1, `core_r`=1, `core_i`=0.
- On `in_valid`&`in_ready`:
  - `sreg`<=`in_data`, `cnt`<=0, `res`<=0.
  - Store `in_data[W-1]` as `msb_q`.
  - Go to SHIFT.

**SHIFT**
- `core_r`=0, `core_i`=`sreg[0]`.
- Each edge:
  - `res`<={`core_y`, `res[W-1:1]`}
  - `sreg`<=`sreg`>>1
  - `cnt`<=`cnt`+1
- On the edge where `cnt`==W-1 (the W-th capture), go to DONE.

**DONE**
- `out_valid`=1, `core_r`=1, `out_data`=`res`, held stable.
- On `out_ready`, go to IDLE.

**Other outputs**
- `busy`=1 in SHIFT and DONE.

**Arithmetic**
- `out_data` = (~`in_data`+1) mod 2^W.
- Input 0 gives 0.
- Input 2^(W-1) gives 2^(W-1).
- `cnt` is ceil(log2(W)) bits wide and never wraps within a word.

**Boundary conditions**
- `in_valid` while not in IDLE: ignored, `in_ready`=0. No buffering.
- `out_ready` high outside DONE: no effect.
- `in_data` changes during SHIFT: no effect, the word was captured at acceptance.
- `r` low at any time, including mid-SHIFT or DONE:
  - State goes to IDLE immediately.
  - `sreg`, `res`, `cnt`, `msb_q` are cleared to 0.
  - The partial word is discarded, not replayed.

**Reset values**
- `in_ready`=1, `core_r`=1.
- `out_valid`, `out_data`, `out_ovf`, `busy`, `core_i` are all 0.

## Timing

- Acceptance edge E0 gives SHIFT during cycles 1..W. Bit k is on `core_i` in cycle k+1 and is captured at edge E(k+1).
- `out_valid` rises after edge EW, so latency is W cycles from acceptance to result.
- With `out_ready` tied high, DONE lasts 1 cycle and IDLE accepts 1 cycle later. Minimum word period is W+2 cycles.
- `core_r` is low for exactly W consecutive cycles per word. It is high in every cycle before the first bit, so a synchronous-clear core is cleared before every word.
- All outputs are registered-state decodes. `core_i` has no combinational path from `in_data`.

## Configuration

- `TC_OVF_EN` defined:
  - `out_ovf` = `msb_q` & `res[W-1]`, valid with `out_valid`.
  - It is 1 only for input 2^(W-1), the most-negative value, whose negation overflows.
- `TC_OVF_EN` undefined:
  - `out_ovf` is tied 0.
  - `msb_q` is not implemented.
- The port exists in both builds.

## Test plan

1. **Basic result and latency:** W=8, accept 0x01 → `out_data`=0xFF, `out_valid` rises exactly 8 cycles after the acceptance edge. Accept 0x7F → 0x81.
2. **Bit-level core drive:** accept 0x06 → `core_i` over SHIFT is 0,1,1,0,0,0,0,0; `core_r` is low exactly 8 cycles; `out_data`=0xFA.
3. **Corner values:** 0x00 → 0x00 with `out_ovf`=0. 0x80 → 0x80 with `out_ovf`=1 when `TC_OVF_EN` is defined, and 0 when undefined.
4. **Backpressure:**
   - Hold `out_ready` low 5 cycles in DONE: `out_valid` and `out_data` stay stable, `in_ready`=0, and an `in_valid` pulse is ignored.
   - Release `out_ready`: IDLE follows 1 cycle later, and the next word 0x02 → 0xFE.
5. **Reset mid-operation:**
   - Drive `r` low after 3 SHIFT cycles: `busy`=0, `in_ready`=1, `core_r`=1 immediately, with no clock needed.
   - Release `r` and accept 0x05 → `out_data`=0xFB with normal latency.
6. **Back-to-back:** hold `in_valid` and `out_ready` high with words 0x03, 0x10, 0xFF → results 0xFD, 0xF0, 0x01, one word every 10 cycles.
